// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store controller:
//   - lsuOpE     : request operation encodings (LW..SH)
//   - lsuStateE  : controller FSM state encoding
//   - LAT_CNT_W  : width of the read-latency down-counter (latency 0..3)
//   - isMisaligned / alignAddr : alignment helpers used by lsu_ctrl
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LB  = 3'd1,
      OP_LBU = 3'd2,
      OP_LH  = 3'd3,
      OP_LHU = 3'd4,
      OP_SW  = 3'd5,
      OP_SB  = 3'd6,
      OP_SH  = 3'd7
   } lsuOpE;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } lsuStateE;

   localparam int LAT_CNT_W = 2;

   // Word ops need both low bits clear, halfword ops need bit 0 clear.
   function automatic logic isMisaligned(input lsuOpE op, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (op)
         OP_LW, OP_SW:         bad = (off != 2'b00);
         OP_LH, OP_LHU, OP_SH: bad = off[0];
         default:              bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Clears the offending low address bits so the access becomes aligned.
   function automatic logic [31:0] alignAddr(input lsuOpE op, input logic [31:0] addr);
      logic [31:0] a;
      a = addr;
      case (op)
         OP_LW, OP_SW:         a = {addr[31:2], 2'b00};
         OP_LH, OP_LHU, OP_SH: a = {addr[31:1], 1'b0};
         default:              a = addr;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// -----------------------------------------------------------------------------
// lsu_lane_mux
// Combinational lane logic for the load/store controller (little-endian lanes).
// Ports:
//   op        in   operation being executed
//   byteOff   in   byte offset within the word (addr[1:0])
//   memWord   in   word read from memory
//   wdata     in   store data (SB uses [7:0], SH uses [15:0])
//   loadData  out  selected lane, sign- or zero-extended per op
//   mergeWord out  memWord with the addressed byte/halfword lane replaced
// -----------------------------------------------------------------------------
module lsu_lane_mux
   import lsu_pkg::*;
(
   input  lsuOpE       op,
   input  logic [1:0]  byteOff,
   input  logic [31:0] memWord,
   input  logic [31:0] wdata,
   output logic [31:0] loadData,
   output logic [31:0] mergeWord
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic [4:0]  byteShift;
   logic [4:0]  halfShift;

   assign byteShift = {byteOff, 3'b000};
   assign halfShift = {byteOff[1], 4'b0000};

   always_comb begin
      byteSel = memWord[byteShift +: 8];
      halfSel = memWord[halfShift +: 16];
      case (op)
         OP_LB:   loadData = {{24{byteSel[7]}}, byteSel};
         OP_LBU:  loadData = {24'd0, byteSel};
         OP_LH:   loadData = {{16{halfSel[15]}}, halfSel};
         OP_LHU:  loadData = {16'd0, halfSel};
         default: loadData = memWord;
      endcase
   end

   always_comb begin
      mergeWord = memWord;
      case (op)
         OP_SB:   mergeWord[byteShift +: 8]  = wdata[7:0];
         OP_SH:   mergeWord[halfShift +: 16] = wdata[15:0];
         default: mergeWord = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store controller driving a word-only data memory. Accepts one request at
// a time; byte/halfword stores are done as read-modify-write.
// Configuration macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned requests complete after one cycle with resp_err=1
//               and no memory access
//   undefined : resp_err is always 0; offending low address bits are cleared
// Parameters:
//   ADDR_BITS    word-address width of the memory (index = ALU_MEM_Addr[ADDR_BITS+1:2])
//   READ_LATENCY cycles from address to MEM_DataOut valid (0..3)
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready/req_op/req_addr/req_wdata : request handshake
//   resp_valid/resp_rdata/resp_err                : one-cycle completion
//   Mem_WrEn/ALU_MEM_Addr/MEM_DataIn/MEM_DataOut  : memory interface
// -----------------------------------------------------------------------------
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_BITS    = 10,
   parameter int READ_LATENCY = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        Mem_WrEn,
   output logic [31:0] ALU_MEM_Addr,
   output logic [31:0] MEM_DataIn,
   input  logic [31:0] MEM_DataOut
);

   if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : gBadAddrBits
      $error("lsu_ctrl: ADDR_BITS must be 1..30");
   end
   if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : gBadLatency
      $error("lsu_ctrl: READ_LATENCY must be 0..3");
   end

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY);

   lsuStateE             state;
   logic [LAT_CNT_W-1:0] latCnt;
   lsuOpE                opQ;
   logic [1:0]           offQ;
   logic [31:0]          wdataQ;

   lsuOpE       reqOp;
   logic        misalign;
   logic [31:0] effAddr;
   logic [31:0] loadData;
   logic [31:0] mergeWord;

   assign reqOp = lsuOpE'(req_op);

`ifdef LSU_ALIGN_CHECK_EN
   assign misalign = isMisaligned(reqOp, req_addr[1:0]);
   assign effAddr  = req_addr;
`else
   assign misalign = 1'b0;
   assign effAddr  = alignAddr(reqOp, req_addr);
`endif

   lsu_lane_mux uLaneMux (
      .op        (opQ),
      .byteOff   (offQ),
      .memWord   (MEM_DataOut),
      .wdata     (wdataQ),
      .loadData  (loadData),
      .mergeWord (mergeWord)
   );

   // Request payload: only meaningful after an accept, so no reset needed.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && req_valid) begin
         opQ    <= reqOp;
         offQ   <= effAddr[1:0];
         wdataQ <= req_wdata;
      end
   end

   // Controller FSM with registered outputs. Mem_WrEn and resp_valid default
   // low every cycle so each is a single-cycle pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         latCnt       <= '0;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= '0;
         Mem_WrEn     <= 1'b0;
         ALU_MEM_Addr <= '0;
         MEM_DataIn   <= '0;
      end else begin
         resp_valid <= 1'b0;
         Mem_WrEn   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready    <= 1'b0;
                  ALU_MEM_Addr <= {effAddr[31:2], 2'b00};
                  if (misalign) begin
                     state      <= ST_DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (reqOp == OP_SW) begin
                     state      <= ST_WRITE;
                     Mem_WrEn   <= 1'b1;
                     MEM_DataIn <= req_wdata;
                  end else begin
                     state  <= ST_READ;
                     latCnt <= LAT_LOAD;
                  end
               end
            end

            ST_READ: begin
               if (latCnt == '0) begin
                  // Last READ cycle: MEM_DataOut is valid at this edge.
                  if (opQ == OP_SB || opQ == OP_SH) begin
                     state      <= ST_WRITE;
                     Mem_WrEn   <= 1'b1;
                     MEM_DataIn <= mergeWord;
                  end else begin
                     state      <= ST_DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= loadData;
                  end
               end else begin
                  latCnt <= latCnt - 1'b1;
               end
            end

            ST_WRITE: begin
               state      <= ST_DONE;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end

            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

   localparam int ADDR_BITS = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        Mem_WrEn;
   logic [31:0] ALU_MEM_Addr;
   logic [31:0] MEM_DataIn;
   logic [31:0] MEM_DataOut;

   int testsRun    = 0;
   int testsFailed = 0;

   localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3,
                          LHU = 3'd4, SW = 3'd5, SB = 3'd6, SH = 3'd7;

   lsu_ctrl #(.ADDR_BITS(ADDR_BITS), .READ_LATENCY(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .Mem_WrEn     (Mem_WrEn),
      .ALU_MEM_Addr (ALU_MEM_Addr),
      .MEM_DataIn   (MEM_DataIn),
      .MEM_DataOut  (MEM_DataOut)
   );

   always #5 clk = ~clk;

   // Synchronous word memory with one cycle read latency.
   logic [31:0] mem [0:(1<<ADDR_BITS)-1];
   logic [31:0] rdReg;
   always @(posedge clk) begin
      rdReg <= mem[ALU_MEM_Addr[ADDR_BITS+1:2]];
      if (Mem_WrEn) mem[ALU_MEM_Addr[ADDR_BITS+1:2]] <= MEM_DataIn;
   end
   assign MEM_DataOut = rdReg;

   // Issues one request and observes it for up to 12 cycles after accept.
   task automatic doReq(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output int respCyc, output int wrCnt, output int wrCyc,
                        output logic [31:0] wrAddr, output logic [31:0] wrData,
                        output logic [31:0] rdata, output logic err);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      respCyc = -1; wrCnt = 0; wrCyc = -1; wrAddr = '0; wrData = '0; rdata = '0; err = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (Mem_WrEn) begin
            wrCnt++; wrCyc = k; wrAddr = ALU_MEM_Addr; wrData = MEM_DataIn;
         end
         if (resp_valid) begin
            respCyc = k; rdata = resp_rdata; err = resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      testsRun++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || Mem_WrEn !== 1'b0 ||
          resp_rdata !== 32'h0 || ALU_MEM_Addr !== 32'h0 || MEM_DataIn !== 32'h0) begin
         testsFailed++;
         $display("FAIL reset_state: ready=%b rv=%b err=%b we=%b rdata=%h addr=%h din=%h, need ready=1 others 0",
                  req_ready, resp_valid, resp_err, Mem_WrEn, resp_rdata, ALU_MEM_Addr, MEM_DataIn);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word();
      int rc, wc, wcy; logic [31:0] wa, wdt, rd; logic e;
      doReq(SW, 32'h4, 32'h0000001F, rc, wc, wcy, wa, wdt, rd, e);
      testsRun++;
      if (wc !== 1 || wcy !== 1 || wa !== 32'h4 || wdt !== 32'h1F || rc !== 2) begin
         testsFailed++;
         $display("FAIL sw_word: writes=%0d wcyc=%0d addr=%h data=%h resp=%0d, need 1 1 00000004 0000001f 2",
                  wc, wcy, wa, wdt, rc);
      end
      doReq(LW, 32'h4, 32'h0, rc, wc, wcy, wa, wdt, rd, e);
      testsRun++;
      if (rd !== 32'h0000001F || rc !== 3 || wc !== 0 || e !== 1'b0) begin
         testsFailed++;
         $display("FAIL lw_word: rdata=%h resp=%0d writes=%0d err=%b, need 0000001f 3 0 0", rd, rc, wc, e);
      end
   endtask

   task automatic test_lanes();
      int rc, wc, wcy; logic [31:0] wa, wdt, rd; logic e;
      logic [2:0]  ops   [6] = '{LB, LB, LH, LB, LBU, LH};
      logic [31:0] addrs [6] = '{32'hB, 32'h8, 32'hA, 32'hC, 32'hC, 32'hC};
      logic [31:0] exps  [6] = '{32'h00000011, 32'h00000044, 32'h00001122,
                                 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0};
      doReq(SW, 32'h8, 32'h11223344, rc, wc, wcy, wa, wdt, rd, e);
      doReq(SW, 32'hC, 32'h000080F0, rc, wc, wcy, wa, wdt, rd, e);
      for (int i = 0; i < 6; i++) begin
         doReq(ops[i], addrs[i], 32'h0, rc, wc, wcy, wa, wdt, rd, e);
         testsRun++;
         if (rd !== exps[i] || rc !== 3 || wc !== 0) begin
            testsFailed++;
            $display("FAIL lane_load_%0d: op=%0d addr=%h rdata=%h resp=%0d writes=%0d, need %h 3 0",
                     i, ops[i], addrs[i], rd, rc, wc, exps[i]);
         end
      end
   endtask

   task automatic test_rmw();
      int rc, wc, wcy; logic [31:0] wa, wdt, rd; logic e;
      doReq(SB, 32'h9, 32'h000000AB, rc, wc, wcy, wa, wdt, rd, e);
      testsRun++;
      if (wc !== 1 || wcy !== 3 || wa !== 32'h8 || wdt !== 32'h1122AB44 || rc !== 4 || rd !== 32'h0) begin
         testsFailed++;
         $display("FAIL sb_rmw: writes=%0d wcyc=%0d addr=%h data=%h resp=%0d rdata=%h, need 1 3 00000008 1122ab44 4 0",
                  wc, wcy, wa, wdt, rc, rd);
      end
      doReq(LW, 32'h8, 32'h0, rc, wc, wcy, wa, wdt, rd, e);
      testsRun++;
      if (rd !== 32'h1122AB44 || rc !== 3) begin
         testsFailed++;
         $display("FAIL sb_readback: rdata=%h resp=%0d, need 1122ab44 3", rd, rc);
      end
      doReq(SH, 32'h6, 32'hFFFF1234, rc, wc, wcy, wa, wdt, rd, e);
      testsRun++;
      if (wc !== 1 || wcy !== 3 || wa !== 32'h4 || wdt !== 32'h1234001F || rc !== 4) begin
         testsFailed++;
         $display("FAIL sh_rmw: writes=%0d wcyc=%0d addr=%h data=%h resp=%0d, need 1 3 00000004 1234001f 4",
                  wc, wcy, wa, wdt, rc);
      end
      doReq(LHU, 32'h6, 32'h0, rc, wc, wcy, wa, wdt, rd, e);
      testsRun++;
      if (rd !== 32'h00001234) begin
         testsFailed++;
         $display("FAIL sh_readback: rdata=%h, need 00001234", rd);
      end
   endtask

   task automatic test_misaligned();
      int rc, wc, wcy; logic [31:0] wa, wdt, rd; logic e;
      doReq(SW, 32'h0, 32'hCAFEF00D, rc, wc, wcy, wa, wdt, rd, e);
      doReq(LW, 32'h2, 32'h0, rc, wc, wcy, wa, wdt, rd, e);
      testsRun++;
`ifdef LSU_ALIGN_CHECK_EN
      if (e !== 1'b1 || rc !== 1 || wc !== 0) begin
         testsFailed++;
         $display("FAIL misaligned_lw: err=%b resp=%0d writes=%0d, need 1 1 0", e, rc, wc);
      end
`else
      if (e !== 1'b0 || rc !== 3 || wc !== 0 || rd !== 32'hCAFEF00D) begin
         testsFailed++;
         $display("FAIL misaligned_lw: err=%b resp=%0d writes=%0d rdata=%h, need 0 3 0 cafef00d", e, rc, wc, rd);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int wc, rv; logic [31:0] wa, wdt, rd; int rc, wcy; logic e;
      wc = 0; rv = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = SH; req_addr = 32'hE; req_wdata = 32'h0000BEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      testsRun++;
      if (Mem_WrEn !== 1'b0 || req_ready !== 1'b1) begin
         testsFailed++;
         $display("FAIL reset_mid_async: we=%b ready=%b, need 0 1", Mem_WrEn, req_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (Mem_WrEn) wc++;
         if (resp_valid) rv++;
      end
      testsRun++;
      if (wc !== 0 || rv !== 0 || req_ready !== 1'b1) begin
         testsFailed++;
         $display("FAIL reset_mid_quiet: writes=%0d resps=%0d ready=%b, need 0 0 1", wc, rv, req_ready);
      end
      doReq(LW, 32'hC, 32'h0, rc, wcy, wcy, wa, wdt, rd, e);
      testsRun++;
      if (rd !== 32'h000080F0) begin
         testsFailed++;
         $display("FAIL reset_mid_mem: word 0xC=%h, need 000080f0", rd);
      end
   endtask

   task automatic test_back_to_back();
      int accCyc, wrCnt, wrCyc, respCnt, resp1, resp2, readyBusy;
      logic [31:0] wrData, wrAddr, rd1;
      logic dropNext;
      accCyc = -1; wrCnt = 0; wrCyc = -1; respCnt = 0; resp1 = -1; resp2 = -1; readyBusy = 0;
      wrData = '0; wrAddr = '0; rd1 = '0; dropNext = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_op = LW; req_addr = 32'h8; req_wdata = 32'h0;
      @(posedge clk);
      #1;
      req_op = SW; req_addr = 32'h10; req_wdata = 32'h00000055;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (dropNext) begin req_valid = 1'b0; dropNext = 1'b0; end
         if (k <= 3 && req_ready) readyBusy++;
         if (Mem_WrEn) begin wrCnt++; wrCyc = k; wrData = MEM_DataIn; wrAddr = ALU_MEM_Addr; end
         if (resp_valid) begin
            respCnt++;
            if (resp1 < 0) begin resp1 = k; rd1 = resp_rdata; end else resp2 = k;
         end
         if (req_valid && req_ready) begin
            if (accCyc < 0) accCyc = k;
            dropNext = 1'b1;
         end
      end
      req_valid = 1'b0;
      testsRun++;
      if (resp1 !== 3 || rd1 !== 32'h1122AB44 || readyBusy !== 0) begin
         testsFailed++;
         $display("FAIL busy_load: resp=%0d rdata=%h readyWhileBusy=%0d, need 3 1122ab44 0", resp1, rd1, readyBusy);
      end
      testsRun++;
      if (accCyc !== 4 || wrCnt !== 1 || wrCyc !== 5 || wrData !== 32'h55 || wrAddr !== 32'h10 ||
          respCnt !== 2 || resp2 !== 6) begin
         testsFailed++;
         $display("FAIL busy_store: acc=%0d writes=%0d wcyc=%0d data=%h addr=%h resps=%0d resp2=%0d, need 4 1 5 00000055 00000010 2 6",
                  accCyc, wrCnt, wrCyc, wrData, wrAddr, respCnt, resp2);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 32'h0;
      test_reset();
      test_word();
      test_lanes();
      test_rmw();
      test_misaligned();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, need bench to finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that acts as the initiator for the MEM-stage data memory. It accepts one load or store request at a time from the EX/MEM pipeline logic and drives `Mem_WrEn`, `ALU_MEM_Addr` and `MEM_DataIn`. It consumes `MEM_DataOut`, returning sign- or zero-extended load data. Byte and halfword stores are built as read-modify-write sequences on the word-only memory.

## Interface
- `ADDR_BITS`, default 10: word-address width of the memory. The memory word index is `ALU_MEM_Addr[ADDR_BITS+1:2]`.
- `READ_LATENCY`, default 1: cycles from address presented to `MEM_DataOut` valid. Legal values are 0..3.

Ports:
- `clk`  in  1  rising-edge clock; the block has one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_op`  in  3  operation code (`lsu_pkg`): LW=0, LB=1, LBU=2, LH=3, LHU=4, SW=5, SB=6, SH=7.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; SB uses [7:0] and SH uses [15:0].
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned request; qualified by `resp_valid`.
- `Mem_WrEn`  out  1  memory write enable.
- `ALU_MEM_Addr`  out  32  memory byte address, with [1:0] forced to 0.
- `MEM_DataIn`  out  32  memory write word.
- `MEM_DataOut`  in  32  memory read word.

## Operation
- FSM states are IDLE, READ, WRITE and DONE. `req_ready` is high only in IDLE.
- On accept, the block latches op, addr and wdata:
  - misaligned request goes to DONE with `resp_err=1` and makes no memory access;
  - SW goes to WRITE;
  - all other ops go to READ.
- READ:
  - `ALU_MEM_Addr` holds the latched word address and `Mem_WrEn=0`.
  - The state lasts `READ_LATENCY+1` cycles, tracked by a down-counter.
  - `MEM_DataOut` is captured at the closing edge of the last READ cycle.
  - Loads then go to DONE; SB and SH go to WRITE.
- WRITE:
  - `Mem_WrEn=1` for exactly one cycle, then the FSM goes to DONE.
  - For SW, `MEM_DataIn` is `req_wdata`.
  - For SB and SH, `MEM_DataIn` is the captured word with the addressed lane replaced.
- DONE: `resp_valid=1` for one cycle, then the FSM returns to IDLE.
- Lanes are little-endian. Byte k is `word[8k+7:8k]` with k=`addr[1:0]`. The halfword is `word[16h+15:16h]` with h=`addr[1]`.
- Load extension: LB and LH sign-extend; LBU and LHU zero-extend.
- Alignment rules: LW and SW need `addr[1:0]==0`; LH, LHU and SH need `addr[0]==0`; byte ops are always aligned.
- `req_valid` while busy is ignored; there is no queuing.

## Timing
- Cycle +1 is the first cycle after the accept edge. Completion timing with L=`READ_LATENCY`:
  - error: `resp_valid` at +1;
  - SW: write at +1, `resp_valid` at +2;
  - loads: `resp_valid` at +(L+2), so +3 at default;
  - SB/SH: write at +(L+2), `resp_valid` at +(L+3).
- A new request can be accepted in the cycle after DONE, when the FSM is back in IDLE.
- Reset values:
  - state IDLE and `req_ready=1`;
  - `resp_valid`, `resp_err`, `resp_rdata`, `Mem_WrEn`, `ALU_MEM_Addr`, `MEM_DataIn` all 0.
- Reset mid-operation:
  - `Mem_WrEn` drops immediately, since reset is asynchronous;
  - no partial RMW write ever reaches memory and no response is produced.
- `resp_rdata` and `resp_err` are valid only in the `resp_valid` cycle and hold until the next DONE.

## Configuration
- Macro `LSU_ALIGN_CHECK_EN`.
- Defined: misaligned requests complete with `resp_err=1` after one cycle and make no memory access.
- Undefined: the alignment check is removed and `resp_err` is tied to 0. Offending low address bits are cleared:
  - LW/SW use `addr & ~3`;
  - halfword ops use `addr & ~1`.
  - The access then proceeds normally.

## Structure
- Package `lsu_pkg` holds the op encodings, the FSM state encoding and the `READ_LATENCY` counter width.
- One combinational sub-module, `lsu_lane_mux`, covers:
  - load lane extraction and extension;
  - store lane merge for SB and SH.

## Test plan
- Word store/load: SW addr 0x4, data 0x0000001F, then LW 0x4.
  - Expect `Mem_WrEn` high exactly one cycle with `ALU_MEM_Addr`=0x4.
  - LW returns `resp_rdata`=0x0000001F at +3.
- Lane loads after SW 0x8 of 0x11223344 and SW 0xC of 0x000080F0:
  - LB 0xB → 0x00000011; LB 0x8 → 0x00000044; LH 0xA → 0x00001122;
  - LB 0xC → 0xFFFFFFF0; LBU 0xC → 0x000000F0; LH 0xC → 0xFFFF80F0.
- Byte RMW: SB 0x9 with data 0xAB over 0x11223344.
  - Expect a single write of 0x1122AB44 at +3 and `resp_valid` at +4.
  - LW 0x8 then returns 0x1122AB44.
- Misaligned LW 0x2 with `LSU_ALIGN_CHECK_EN` defined: `resp_err=1` at +1 and `Mem_WrEn` never asserts.
- Misaligned LW 0x2 without the macro: reads word 0x0 and `resp_err=0`.
- Reset asserted during READ of SH 0xE with data 0xBEEF:
  - `Mem_WrEn` stays 0, no `resp_valid`, `req_ready=1` after release;
  - word 0xC is unchanged.
- Busy hold: keep `req_valid` high with a second SW during a load.
  - The second SW is accepted only in the cycle after the first `resp_valid`.
  - No request is lost or duplicated.
